polynomial3_coeff_loader: RTL and testbench
===========================================

Name: polynomial3_coeff_loader

Overview:
- Upstream neighbour of the Polynomial3 compute stage.
- Takes a narrow byte stream from the host/config path and assembles each frame into one {a,b,c} coefficient set.
- Presents the set on a valid/ready source port that connects directly to the compute stage's coefficient sink.
- Double-buffered, so the next frame can assemble while the current set waits for acceptance. Malformed frames are detected, discarded and resynchronised.

Parameters:
A_W, 16, width of coefficient a in bits; multiple of 8
B_W, 16, width of coefficient b in bits; multiple of 8
C_W, 24, width of coefficient c in bits; multiple of 8
CNT_W, 16, width of accepted-frame and error counters

Ports:
clk  input  1  sole clock; all logic on posedge
rstn  input  1  reset, synchronous, active-low; sampled on posedge clk
in_data  input  8  coefficient byte stream
in_valid  input  1  in_data valid
in_last  input  1  marks final byte of a frame
in_ready  output  1  loader accepts byte this cycle
abc_a  output  A_W  coefficient a
abc_b  output  B_W  coefficient b
abc_c  output  C_W  coefficient c
abc_valid  output  1  coefficient set valid
abc_ready  input  1  downstream accepts set
err_pulse  output  1  one-cycle pulse per malformed frame
frame_cnt  output  CNT_W  coefficient sets handed off (abc_valid & abc_ready)
err_cnt  output  CNT_W  malformed frames detected

Behaviour:
- Reset (rstn=0 at posedge):
  - abc_valid=0, abc_a/b/c=0, err_pulse=0, frame_cnt=0, err_cnt=0, in_ready=0 in that cycle.
  - FSM to LOAD_A, byte index 0, assembly registers cleared.
  - Reset mid-frame discards partial data; no set is emitted.
- Frame format:
  - N = (A_W+B_W+C_W)/8 bytes (default 7), fields in order a, b, c.
  - Each field is little-endian: first byte is bits [7:0].
- Byte transfer occurs when in_valid & in_ready.
- FSM states:
  - LOAD_A, LOAD_B, LOAD_C: fill the assembly register for the field.
  - Per-field byte index advances on each transfer.
  - Move to the next state after the field's last byte (A_W/8, B_W/8, C_W/8 bytes).
  - FULL: assembly holds a complete set awaiting transfer to the output register.
  - RESYNC: discard bytes until in_last.
- in_ready = 1 in LOAD_A/LOAD_B/LOAD_C/RESYNC; 0 in FULL.
- Early in_last (on any byte before byte N-1):
  - Frame discarded; err_pulse=1 next cycle; err_cnt+1; FSM to LOAD_A.
- Missing in_last on byte N-1:
  - Frame discarded; err_pulse=1 next cycle; err_cnt+1; FSM to RESYNC.
  - RESYNC consumes bytes through and including the next in_last, then returns to LOAD_A with no further error counted.
- Valid completion: byte N-1 with in_last goes to FULL.
- Transfer assembly→output:
  - Happens in any cycle where FSM=FULL and (abc_valid=0 or abc_ready=1).
  - Output registers load, abc_valid=1 next cycle, FSM to LOAD_A.
  - Minimum latency: last byte accepted at cycle t → FULL at t+1 → abc_valid at t+2.
- Output hold:
  - While abc_valid=1 and abc_ready=0, abc_a/b/c and abc_valid hold stable; the next frame may fully assemble meanwhile (reaching FULL).
  - Handoff with no pending FULL: abc_valid drops next cycle.
  - Handoff while FULL: new set loads; abc_valid stays 1 (back-to-back, no bubble).
  - abc_valid never deasserts without a handshake.
- Counters:
  - frame_cnt increments on abc_valid & abc_ready.
  - err_cnt increments per malformed frame.
  - Both wrap modulo 2^CNT_W.
- in_valid=0 stalls assembly indefinitely with no timeout.
- in_data/in_last are ignored when in_ready=0.

Test Plan:
- Single frame: bytes 2A 00 B8 00 02 00 00 (in_last on 7th), abc_ready=1 → abc_a=42, abc_b=184, abc_c=2, abc_valid one cycle, 2 cycles after last byte; frame_cnt=1.
- Backpressure: abc_ready=0; send two frames back-to-back → first set held stable; second assembles and in_ready=0 in FULL. Raise abc_ready for 2 cycles → sets delivered in order on consecutive cycles, frame_cnt=2.
- Early last: 4 bytes with in_last on byte 4 → err_pulse once, err_cnt=1, no abc_valid. A following good frame is delivered correctly.
- Missing last: 9 bytes with in_last only on byte 9 → err_cnt=1, FSM in RESYNC for bytes 8-9, nothing emitted. The next good frame is delivered.
- Reset mid-frame: rstn=0 for 1 cycle after 3 bytes → all outputs and counters zero. A subsequent full frame decodes with no residue from the partial frame.
- Random in_valid/abc_ready gaps, 1000 random frames with 10% malformed → scoreboard matches every good set in order; err_cnt equals the injected error count.

Source files
------------

// File: rtl/polynomial3_coeff_loader.sv
// -----------------------------------------------------------------------------
// polynomial3_coeff_loader
//
// Assembles a little-endian byte stream into one {a,b,c} coefficient set per
// frame and hands it to the Polynomial3 compute stage over valid/ready.
// A frame is (A_W+B_W+C_W)/8 bytes: the bytes of a, then b, then c, each
// field least-significant byte first. in_last must mark exactly the final
// byte. An early in_last drops the frame and restarts at field a. A missing
// in_last on the final byte drops the frame and discards input up to and
// including the next in_last. Each malformed frame gives one err_pulse.
//
// The design is double-buffered. An assembly register set collects the next
// frame while the output register set holds the current one for the consumer.
//
// Ports
//   clk        sole clock, all state changes on posedge
//   rstn       synchronous active-low reset
//   in_data    coefficient byte
//   in_valid   in_data is valid
//   in_last    in_data is the final byte of the frame
//   in_ready   loader accepts a byte this cycle
//   abc_a/b/c  coefficient set presented downstream
//   abc_valid  coefficient set valid
//   abc_ready  downstream accepts the set
//   err_pulse  one-cycle pulse per malformed frame
//   frame_cnt  sets handed off (abc_valid & abc_ready), wraps
//   err_cnt    malformed frames detected, wraps
// -----------------------------------------------------------------------------
module polynomial3_coeff_loader #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int C_W   = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [A_W-1:0]   abc_a,
  output logic [B_W-1:0]   abc_b,
  output logic [C_W-1:0]   abc_c,
  output logic             abc_valid,
  input  logic             abc_ready,
  output logic             err_pulse,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int A_BYTES   = A_W / 8;
  localparam int B_BYTES   = B_W / 8;
  localparam int C_BYTES   = C_W / 8;
  localparam int AB_MAX    = (A_BYTES > B_BYTES) ? A_BYTES : B_BYTES;
  localparam int MAX_BYTES = (AB_MAX > C_BYTES) ? AB_MAX : C_BYTES;
  localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  localparam logic [IDX_W-1:0] A_LAST = IDX_W'(A_BYTES - 1);
  localparam logic [IDX_W-1:0] B_LAST = IDX_W'(B_BYTES - 1);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(C_BYTES - 1);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_C,
    FULL,
    RESYNC
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [A_W-1:0]   asm_a_q, asm_a_d;
  logic [B_W-1:0]   asm_b_q, asm_b_d;
  logic [C_W-1:0]   asm_c_q, asm_c_d;
  logic [A_W-1:0]   out_a_q, out_a_d;
  logic [B_W-1:0]   out_b_q, out_b_d;
  logic [C_W-1:0]   out_c_q, out_c_d;
  logic             abc_valid_q, abc_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic xfer;
  logic bad_frame;

  // in_ready is held low during reset, so no byte is taken in that cycle.
  assign in_ready = rstn && (state_q != FULL);
  assign xfer     = in_valid && in_ready;

  // Next-state logic. The handshake drop comes first so that a FULL transfer
  // in the same cycle can keep abc_valid high, giving back-to-back sets.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_a_d     = asm_a_q;
    asm_b_d     = asm_b_q;
    asm_c_d     = asm_c_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    abc_valid_d = abc_valid_q;
    err_pulse_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    bad_frame   = 1'b0;

    if (abc_valid_q && abc_ready) begin
      abc_valid_d = 1'b0;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end

    case (state_q)
      LOAD_A: begin
        if (xfer) begin
          asm_a_d[8*int'(idx_q) +: 8] = in_data;
          if (in_last) begin
            bad_frame = 1'b1;
            state_d   = LOAD_A;
            idx_d     = '0;
          end else if (idx_q == A_LAST) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      LOAD_B: begin
        if (xfer) begin
          asm_b_d[8*int'(idx_q) +: 8] = in_data;
          if (in_last) begin
            bad_frame = 1'b1;
            state_d   = LOAD_A;
            idx_d     = '0;
          end else if (idx_q == B_LAST) begin
            state_d = LOAD_C;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      LOAD_C: begin
        if (xfer) begin
          asm_c_d[8*int'(idx_q) +: 8] = in_data;
          if (idx_q == C_LAST) begin
            // The final byte of the frame must carry in_last. Without it the
            // stream is out of step, so skip ahead to the next frame boundary.
            idx_d = '0;
            if (in_last) begin
              state_d = FULL;
            end else begin
              bad_frame = 1'b1;
              state_d   = RESYNC;
            end
          end else if (in_last) begin
            bad_frame = 1'b1;
            state_d   = LOAD_A;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      FULL: begin
        if (!abc_valid_q || abc_ready) begin
          out_a_d     = asm_a_q;
          out_b_d     = asm_b_q;
          out_c_d     = asm_c_q;
          abc_valid_d = 1'b1;
          state_d     = LOAD_A;
        end
      end

      RESYNC: begin
        if (xfer && in_last) begin
          state_d = LOAD_A;
        end
      end

      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase

    if (bad_frame) begin
      err_pulse_d = 1'b1;
      err_cnt_d   = err_cnt_q + CNT_W'(1);
    end
  end

  // All state, including the FSM, registered with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= LOAD_A;
      idx_q       <= '0;
      asm_a_q     <= '0;
      asm_b_q     <= '0;
      asm_c_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      abc_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_a_q     <= asm_a_d;
      asm_b_q     <= asm_b_d;
      asm_c_q     <= asm_c_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      abc_valid_q <= abc_valid_d;
      err_pulse_q <= err_pulse_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign abc_a     = out_a_q;
  assign abc_b     = out_b_q;
  assign abc_c     = out_c_q;
  assign abc_valid = abc_valid_q;
  assign err_pulse = err_pulse_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_polynomial3_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_polynomial3_coeff_loader
//
// Bench for polynomial3_coeff_loader with default parameters.
// Each good frame pushes its expected {a,b,c} onto a queue when it is sent.
// A monitor pops the queue on every output handshake and compares the set.
// The monitor also checks that a set stays stable while it is held back.
// The scenario tasks check timing, counters and error pulses.
// -----------------------------------------------------------------------------
module tb_polynomial3_coeff_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [23:0] c;
  } set_t;

  logic        clk;
  logic        rstn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] abc_a;
  logic [15:0] abc_b;
  logic [23:0] abc_c;
  logic        abc_valid;
  logic        abc_ready;
  logic        err_pulse;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int   total = 0;
  int   bad = 0;
  int   hs_count = 0;
  int   err_seen = 0;
  bit   rand_ready = 1'b0;
  set_t exp_q[$];
  set_t mon_e;
  set_t prev_set;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_rstn = 1'b0;

  polynomial3_coeff_loader dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .abc_a     (abc_a),
    .abc_b     (abc_b),
    .abc_c     (abc_c),
    .abc_valid (abc_valid),
    .abc_ready (abc_ready),
    .err_pulse (err_pulse),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random consumer backpressure, only while the random test enables it.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      abc_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard monitor. A handshake at the coming posedge is visible at the
  // preceding negedge, because both sides change only just after a posedge.
  always @(negedge clk) begin
    if (rstn && abc_valid && abc_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL scoreboard_unexpected: got a=%h b=%h c=%h, expected no set", abc_a, abc_b, abc_c);
      end else begin
        mon_e = exp_q.pop_front();
        if ({abc_a, abc_b, abc_c} !== mon_e) begin
          bad++;
          $display("[TB] FAIL scoreboard_set: got a=%h b=%h c=%h, expected a=%h b=%h c=%h",
                   abc_a, abc_b, abc_c, mon_e.a, mon_e.b, mon_e.c);
        end
      end
      hs_count++;
    end
    if (rstn && err_pulse) err_seen++;
    if (rstn && prev_rstn && prev_valid && !prev_ready) begin
      total++;
      if (abc_valid !== 1'b1 || {abc_a, abc_b, abc_c} !== prev_set) begin
        bad++;
        $display("[TB] FAIL hold_stable: got v=%b a=%h b=%h c=%h, expected v=1 a=%h b=%h c=%h",
                 abc_valid, abc_a, abc_b, abc_c, prev_set.a, prev_set.b, prev_set.c);
      end
    end
    prev_rstn  = rstn;
    prev_valid = abc_valid;
    prev_ready = abc_ready;
    prev_set   = {abc_a, abc_b, abc_c};
  end

  // Drive one byte and wait for the loader to take it. Called just after a
  // posedge, and returns just after the posedge that accepted the byte.
  task automatic send_byte(input logic [7:0] d, input logic l, input bit gaps);
    bit accepted;
    int waited;
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    accepted = 1'b0;
    waited   = 0;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL send_byte_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
    end
  endtask

  task automatic send_good(input logic [15:0] a, input logic [15:0] b, input logic [23:0] c, input bit gaps);
    logic [55:0] raw;
    raw = {c, b, a};
    exp_q.push_back({a, b, c});
    for (int i = 0; i < 7; i++) send_byte(raw[i*8 +: 8], (i == 6), gaps);
  endtask

  task automatic send_bad_early(input int len, input bit gaps);
    for (int i = 0; i < len; i++) send_byte(8'($urandom), (i == len - 1), gaps);
  endtask

  task automatic send_bad_missing(input int len, input bit gaps);
    for (int i = 0; i < len; i++) send_byte(8'($urandom), (i == len - 1), gaps);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || abc_valid !== 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() != 0 || abc_valid !== 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: pending=%0d abc_valid=%b, expected 0 and 0", exp_q.size(), abc_valid);
    end
  endtask

  task automatic test_reset;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    abc_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready);
    end
    total++;
    if ({abc_valid, err_pulse, frame_cnt, err_cnt, abc_a, abc_b, abc_c} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got v=%b e=%b fc=%0d ec=%0d a=%h b=%h c=%h, expected all 0",
               abc_valid, err_pulse, frame_cnt, err_cnt, abc_a, abc_b, abc_c);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_ready: got %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    abc_ready = 1'b1;
    send_good(16'd42, 16'd184, 24'd2, 1'b0);
    @(negedge clk);
    total++;
    if (abc_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_latency_t1: abc_valid=%b, expected 0", abc_valid);
    end
    @(negedge clk);
    total++;
    if (abc_valid !== 1'b1 || abc_a !== 16'd42 || abc_b !== 16'd184 || abc_c !== 24'd2) begin
      bad++;
      $display("[TB] FAIL single_latency_t2: v=%b a=%0d b=%0d c=%0d, expected v=1 a=42 b=184 c=2",
               abc_valid, abc_a, abc_b, abc_c);
    end
    @(negedge clk);
    total++;
    if (abc_valid !== 1'b0 || frame_cnt !== 16'd1) begin
      bad++;
      $display("[TB] FAIL single_after: v=%b frame_cnt=%0d, expected v=0 frame_cnt=1", abc_valid, frame_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    abc_ready = 1'b0;
    send_good(16'h1234, 16'h5678, 24'h9ABCDE, 1'b0);
    send_good(16'hFEDC, 16'hBA98, 24'h765432, 1'b0);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || abc_valid !== 1'b1 || abc_a !== 16'h1234) begin
      bad++;
      $display("[TB] FAIL bp_held: in_ready=%b v=%b a=%h, expected in_ready=0 v=1 a=1234", in_ready, abc_valid, abc_a);
    end
    @(posedge clk);
    #1;
    abc_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (abc_valid !== 1'b1 || abc_a !== 16'hFEDC || abc_c !== 24'h765432) begin
      bad++;
      $display("[TB] FAIL bp_back_to_back: v=%b a=%h c=%h, expected v=1 a=fedc c=765432", abc_valid, abc_a, abc_c);
    end
    @(posedge clk);
    #1;
    abc_ready = 1'b0;
    @(negedge clk);
    total++;
    if (abc_valid !== 1'b0 || frame_cnt !== 16'd3) begin
      bad++;
      $display("[TB] FAIL bp_count: v=%b frame_cnt=%0d, expected v=0 frame_cnt=3", abc_valid, frame_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_early_last;
    int e0;
    e0 = err_seen;
    abc_ready = 1'b1;
    send_bad_early(4, 1'b0);
    @(negedge clk);
    total++;
    if (err_pulse !== 1'b1 || err_cnt !== 16'd1) begin
      bad++;
      $display("[TB] FAIL early_pulse: err_pulse=%b err_cnt=%0d, expected 1 and 1", err_pulse, err_cnt);
    end
    @(negedge clk);
    total++;
    if (err_pulse !== 1'b0 || abc_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL early_after: err_pulse=%b v=%b, expected 0 and 0", err_pulse, abc_valid);
    end
    @(posedge clk);
    #1;
    send_good(16'hA5A5, 16'h0F0F, 24'h123456, 1'b0);
    wait_drain(50);
    total++;
    if (frame_cnt !== 16'd4 || err_seen - e0 != 1) begin
      bad++;
      $display("[TB] FAIL early_recover: frame_cnt=%0d pulses=%0d, expected 4 and 1", frame_cnt, err_seen - e0);
    end
  endtask

  task automatic test_missing_last;
    int e0;
    e0 = err_seen;
    abc_ready = 1'b1;
    send_bad_missing(9, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (err_cnt !== 16'd2 || err_seen - e0 != 1 || abc_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL missing_err: err_cnt=%0d pulses=%0d v=%b, expected 2, 1, 0", err_cnt, err_seen - e0, abc_valid);
    end
    @(posedge clk);
    #1;
    send_good(16'h0001, 16'h8000, 24'hFFFFFF, 1'b0);
    wait_drain(50);
    total++;
    if (frame_cnt !== 16'd5 || err_cnt !== 16'd2) begin
      bad++;
      $display("[TB] FAIL missing_recover: frame_cnt=%0d err_cnt=%0d, expected 5 and 2", frame_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid;
    abc_ready = 1'b1;
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_in_ready: got %b, expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    hs_count = 0;
    err_seen = 0;
    @(negedge clk);
    total++;
    if ({abc_valid, err_pulse, frame_cnt, err_cnt, abc_a, abc_b, abc_c} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: v=%b e=%b fc=%0d ec=%0d a=%h b=%h c=%h, expected all 0",
               abc_valid, err_pulse, frame_cnt, err_cnt, abc_a, abc_b, abc_c);
    end
    @(posedge clk);
    #1;
    send_good(16'hBEEF, 16'hCAFE, 24'h00D00D, 1'b0);
    wait_drain(50);
    total++;
    if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      bad++;
      $display("[TB] FAIL midreset_frame: frame_cnt=%0d err_cnt=%0d, expected 1 and 0", frame_cnt, err_cnt);
    end
  endtask

  task automatic test_random;
    int injected;
    int good;
    int base;
    injected = 0;
    good     = 0;
    base     = int'(frame_cnt);
    rand_ready = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) send_bad_early($urandom_range(1, 6), 1'b1);
        else send_bad_missing($urandom_range(8, 10), 1'b1);
        injected++;
      end else begin
        send_good(16'($urandom), 16'($urandom), 24'($urandom), 1'b1);
        good++;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    abc_ready = 1'b1;
    wait_drain(200);
    total++;
    if (err_cnt !== 16'(injected)) begin
      bad++;
      $display("[TB] FAIL random_err_cnt: got %0d, expected %0d", err_cnt, injected);
    end
    total++;
    if (frame_cnt !== 16'(base + good) || hs_count != base + good) begin
      bad++;
      $display("[TB] FAIL random_frame_cnt: got %0d (handshakes %0d), expected %0d", frame_cnt, hs_count, base + good);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
